// File: rtl/qspi_pkg.sv
// Shared QSPI definitions: receive FSM states, io lane modes and samples-per-byte.
// The transmit datapath imports this package too.
package qspi_pkg;

   typedef enum logic [1:0] {
      RX_IDLE  = 2'd0,
      RX_DUMMY = 2'd1,
      RX_DATA  = 2'd2,
      RX_DONE  = 2'd3
   } rx_state_t;

   localparam logic [1:0] IO_MODE_SINGLE = 2'b00;
   localparam logic [1:0] IO_MODE_DUAL   = 2'b01;
   localparam logic [1:0] IO_MODE_QUAD   = 2'b10;

   localparam int SPB_SINGLE = 8;
   localparam int SPB_DUAL   = 4;
   localparam int SPB_QUAD   = 2;

   // Mode 2'b11 is not a real lane configuration; it falls back to single.
   function automatic logic [1:0] norm_io_mode(input logic [1:0] mode);
      return (mode == 2'b11) ? IO_MODE_SINGLE : mode;
   endfunction

   function automatic logic [2:0] last_sample_idx(input logic [1:0] mode);
      case (mode)
         IO_MODE_DUAL: return 3'(SPB_DUAL - 1);
         IO_MODE_QUAD: return 3'(SPB_QUAD - 1);
         default:      return 3'(SPB_SINGLE - 1);
      endcase
   endfunction

endpackage

// File: rtl/qspi_rx_datapath_if.sv
// Read-data handshake between the QSPI receive datapath (master) and the AHB
// slave datapath (slave).
interface qspi_rx_datapath_if #(
   parameter int DATA_W = 32
);
   logic [DATA_W-1:0] rdata_out;
   logic              rdata_valid_out;
   logic              rdata_ready_in;

   modport master (
      output rdata_out,
      output rdata_valid_out,
      input  rdata_ready_in
   );

   modport slave (
      input  rdata_out,
      input  rdata_valid_out,
      output rdata_ready_in
   );
endinterface

// File: rtl/qspi_rx_shift_reg.sv
// Mode-aware 8-bit deserializer: shifts 1, 2 or 4 io bits per sample, MSB first,
// and flags the sample that completes a byte (byte_o is valid with byte_done_o).
module qspi_rx_shift_reg
   import qspi_pkg::*;
(
   input  logic       h_clk,
   input  logic       h_rstn,
   input  logic       clear_i,
   input  logic       sample_en_i,
   input  logic [1:0] mode_i,
   input  logic [3:0] io_i,
   output logic [7:0] byte_o,
   output logic       byte_done_o
);

   logic [7:0] shift_q;
   logic [7:0] shift_d;
   logic [2:0] cnt_q;
   logic       last_sample;

   always_comb begin
      // NOTE: shift_d gets a default before the case so every path assigns it and no latch is inferred.
      shift_d = {shift_q[6:0], io_i[1]};
      case (mode_i)
         IO_MODE_DUAL: shift_d = {shift_q[5:0], io_i[1:0]};
         IO_MODE_QUAD: shift_d = {shift_q[3:0], io_i};
         default:      ;
      endcase
   end

   assign last_sample = (cnt_q == last_sample_idx(mode_i));
   assign byte_o      = shift_d;
   assign byte_done_o = sample_en_i && last_sample;

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge h_clk or negedge h_rstn) begin
      if (!h_rstn) begin
         shift_q <= '0;
         cnt_q   <= '0;
      end else if (clear_i) begin
         shift_q <= '0;
         cnt_q   <= '0;
      end else if (sample_en_i) begin
         shift_q <= shift_d;
         cnt_q   <= last_sample ? 3'd0 : cnt_q + 3'd1;
      end
   end

endmodule

// File: rtl/qspi_rx_datapath.sv
// QSPI receive datapath: dummy-cycle skip, single/dual/quad sampling, little-endian
// 32-bit word assembly and a one-deep holding register on a valid/ready handshake.
module qspi_rx_datapath
   import qspi_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int LEN_W  = 8
) (
   input  logic               h_clk,
   input  logic               h_rstn,
   input  logic               start_in,
   input  logic               abort_in,
   input  logic [1:0]         no_io_lines_use_in,
   input  logic [4:0]         dummy_cycles_in,
   input  logic [LEN_W-1:0]   xfer_bytes_in,
   input  logic               sample_en_in,
   input  logic               io0_in,
   input  logic               io1_in,
   input  logic               io2_in,
   input  logic               io3_in,
   qspi_rx_datapath_if.master rd_if,
   output logic               busy_out,
   output logic               rx_done_out,
   output logic               overrun_err_out
);

   rx_state_t         state_q;
   logic [1:0]        mode_q;
   logic [4:0]        dummy_cnt_q;
   logic [LEN_W-1:0]  bytes_rem_q;
   logic [1:0]        byte_idx_q;
   logic              busy_q;
   logic              done_q;
   logic [DATA_W-1:0] word_q;
   logic [DATA_W-1:0] word_d;
   logic [DATA_W-1:0] hold_q;
   logic              valid_q;
   logic              overrun_q;

   logic       start_ok;
   logic       data_sample;
   logic       last_byte;
   logic       push;
   logic       accept;
   logic [7:0] rx_byte;
   logic       byte_done;

   assign start_ok    = start_in && !abort_in && (state_q == RX_IDLE);
   assign data_sample = sample_en_in && !abort_in && (state_q == RX_DATA);
   assign last_byte   = (bytes_rem_q == LEN_W'(1));
   assign push        = byte_done && ((byte_idx_q == 2'd3) || last_byte);
   assign accept      = valid_q && rd_if.rdata_ready_in;

   qspi_rx_shift_reg u_shift (
      .h_clk       (h_clk),
      .h_rstn      (h_rstn),
      .clear_i     (abort_in || start_ok),
      .sample_en_i (data_sample),
      .mode_i      (mode_q),
      .io_i        ({io3_in, io2_in, io1_in, io0_in}),
      .byte_o      (rx_byte),
      .byte_done_o (byte_done)
   );

   always_comb begin
      word_d = word_q;
      word_d[{byte_idx_q, 3'b000} +: 8] = rx_byte;
   end

   // Sequencer: state plus the registered busy/done outputs and the counters.
   always_ff @(posedge h_clk or negedge h_rstn) begin
      if (!h_rstn) begin
         state_q     <= RX_IDLE;
         mode_q      <= IO_MODE_SINGLE;
         dummy_cnt_q <= '0;
         bytes_rem_q <= '0;
         byte_idx_q  <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else if (abort_in) begin
         state_q     <= RX_IDLE;
         dummy_cnt_q <= '0;
         bytes_rem_q <= '0;
         byte_idx_q  <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         case (state_q)
            RX_IDLE: begin
               done_q <= 1'b0;
               if (start_in) begin
                  mode_q      <= norm_io_mode(no_io_lines_use_in);
                  dummy_cnt_q <= dummy_cycles_in;
                  bytes_rem_q <= xfer_bytes_in;
                  byte_idx_q  <= '0;
                  busy_q      <= 1'b1;
                  if (dummy_cycles_in != '0) begin
                     state_q <= RX_DUMMY;
                  end else if (xfer_bytes_in == '0) begin
                     state_q <= RX_DONE;
                     done_q  <= 1'b1;
                  end else begin
                     state_q <= RX_DATA;
                  end
               end
            end
            RX_DUMMY: begin
               if (sample_en_in) begin
                  dummy_cnt_q <= dummy_cnt_q - 5'd1;
                  if (dummy_cnt_q == 5'd1) begin
                     if (bytes_rem_q == '0) begin
                        state_q <= RX_DONE;
                        done_q  <= 1'b1;
                     end else begin
                        state_q <= RX_DATA;
                     end
                  end
               end
            end
            RX_DATA: begin
               if (byte_done) begin
                  bytes_rem_q <= bytes_rem_q - LEN_W'(1);
                  byte_idx_q  <= byte_idx_q + 2'd1;
                  if (last_byte) begin
                     state_q <= RX_DONE;
                     done_q  <= 1'b1;
                  end
               end
            end
            default: begin
               state_q <= RX_IDLE;
               done_q  <= 1'b0;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   // Word assembly and holding register; a push into an unaccepted word is dropped.
   always_ff @(posedge h_clk or negedge h_rstn) begin
      if (!h_rstn) begin
         word_q    <= '0;
         hold_q    <= '0;
         valid_q   <= 1'b0;
         overrun_q <= 1'b0;
      end else if (abort_in) begin
         word_q  <= '0;
         hold_q  <= '0;
         valid_q <= 1'b0;
      end else begin
         if (start_ok) begin
            word_q    <= '0;
            overrun_q <= 1'b0;
         end
         if (byte_done) begin
            word_q <= push ? '0 : word_d;
         end
         if (push) begin
            if (valid_q && !rd_if.rdata_ready_in) begin
               overrun_q <= 1'b1;
            end else begin
               hold_q  <= word_d;
               valid_q <= 1'b1;
            end
         end else if (accept) begin
            valid_q <= 1'b0;
         end
      end
   end

   assign rd_if.rdata_out       = hold_q;
   assign rd_if.rdata_valid_out = valid_q;
   assign busy_out              = busy_q;
   assign rx_done_out           = done_q;
   assign overrun_err_out       = overrun_q;

endmodule

// File: tb/tb_qspi_rx_datapath.sv
// Self-checking bench for qspi_rx_datapath: directed scenarios plus randomized
// transfers compared against a byte-list packing model.
module tb_qspi_rx_datapath;
   import qspi_pkg::*;

   localparam int LEN_W = 8;

   logic             h_clk = 1'b0;
   logic             h_rstn;
   logic             start_in;
   logic             abort_in;
   logic [1:0]       mode_in;
   logic [4:0]       dummy_in;
   logic [LEN_W-1:0] xfer_in;
   logic             sample_en;
   logic             io0, io1, io2, io3;
   logic             busy, done, overrun;

   qspi_rx_datapath_if rd_if ();

   qspi_rx_datapath #(.DATA_W(32), .LEN_W(LEN_W)) dut (
      .h_clk              (h_clk),
      .h_rstn             (h_rstn),
      .start_in           (start_in),
      .abort_in           (abort_in),
      .no_io_lines_use_in (mode_in),
      .dummy_cycles_in    (dummy_in),
      .xfer_bytes_in      (xfer_in),
      .sample_en_in       (sample_en),
      .io0_in             (io0),
      .io1_in             (io1),
      .io2_in             (io2),
      .io3_in             (io3),
      .rd_if              (rd_if),
      .busy_out           (busy),
      .rx_done_out        (done),
      .overrun_err_out    (overrun)
   );

   always #5 h_clk = ~h_clk;

   int errors = 0;
   int checks = 0;
   int done_cnt = 0;
   int busy_cnt = 0;
   logic [31:0] obs_q[$];
   logic [31:0] exp_q[$];
   logic [7:0]  bytes_q[$];

   always @(negedge h_clk) begin
      if (done) done_cnt++;
      if (busy) busy_cnt++;
      if (rd_if.rdata_valid_out && rd_if.rdata_ready_in) obs_q.push_back(rd_if.rdata_out);
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // Inputs change 1 ns after the rising edge; outputs are read there too.
   task automatic step();
      @(posedge h_clk);
      #1;
   endtask

   function automatic int lanes(input logic [1:0] mode);
      if (mode == 2'b10) return 4;
      if (mode == 2'b01) return 2;
      return 1;
   endfunction

   // Reference: bytes packed little-endian, four per word, zero-filled tail.
   function automatic void build_exp();
      logic [31:0] w;
      exp_q.delete();
      w = '0;
      for (int i = 0; i < bytes_q.size(); i++) begin
         w = w | ({24'd0, bytes_q[i]} << (8 * (i % 4)));
         if ((i % 4 == 3) || (i == bytes_q.size() - 1)) begin
            exp_q.push_back(w);
            w = '0;
         end
      end
   endfunction

   task automatic drive_bits(input logic [1:0] mode, input logic [3:0] bits);
      {io3, io2, io1, io0} = 4'($urandom);
      case (lanes(mode))
         4: {io3, io2, io1, io0} = bits;
         2: {io1, io0} = bits[1:0];
         default: io1 = bits[0];
      endcase
   endtask

   task automatic pulse();
      sample_en = 1'b1;
      step();
      sample_en = 1'b0;
   endtask

   task automatic gap(input bit en);
      if (en) repeat ($urandom_range(0, 2)) step();
   endtask

   task automatic send_junk(input int n, input bit gaps);
      for (int i = 0; i < n; i++) begin
         gap(gaps);
         {io3, io2, io1, io0} = 4'($urandom);
         pulse();
      end
   endtask

   task automatic send_byte(input logic [1:0] mode, input logic [7:0] b, input bit gaps);
      int w;
      int v;
      w = lanes(mode);
      for (int s = 0; s < 8 / w; s++) begin
         gap(gaps);
         v = (int'(b) >> (8 - w * (s + 1))) & ((1 << w) - 1);
         drive_bits(mode, v[3:0]);
         pulse();
      end
   endtask

   task automatic send_bytes(input logic [1:0] mode, input bit gaps);
      for (int i = 0; i < bytes_q.size(); i++) send_byte(mode, bytes_q[i], gaps);
   endtask

   task automatic start_xfer(input logic [1:0] mode, input logic [4:0] dummy, input logic [7:0] n);
      mode_in  = mode;
      dummy_in = dummy;
      xfer_in  = n;
      start_in = 1'b1;
      step();
      start_in = 1'b0;
      mode_in  = 2'($urandom);
      dummy_in = 5'($urandom);
      xfer_in  = 8'($urandom);
   endtask

   task automatic wait_idle(input string tag);
      int k;
      k = 0;
      while (busy && k < 20) begin
         step();
         k++;
      end
      check(tag, {31'd0, busy}, 32'd0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int base;
      int d0;
      int b0;
      logic [7:0] cur;

      h_rstn = 1'b0;
      start_in = 1'b0;
      abort_in = 1'b0;
      mode_in = '0;
      dummy_in = '0;
      xfer_in = '0;
      sample_en = 1'b0;
      {io3, io2, io1, io0} = '0;
      rd_if.rdata_ready_in = 1'b1;

      #12;
      check("rst_rdata", rd_if.rdata_out, 32'd0);
      check("rst_valid", {31'd0, rd_if.rdata_valid_out}, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_done", {31'd0, done}, 32'd0);
      check("rst_overrun", {31'd0, overrun}, 32'd0);
      #5 h_rstn = 1'b1;
      step();

      // Single mode, no dummy, DE AD BE EF in 32 back-to-back pulses.
      bytes_q = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
      start_xfer(2'b00, 5'd0, 8'd4);
      check("t1_busy_after_start", {31'd0, busy}, 32'd1);
      for (int s = 0; s < 32; s++) begin
         cur = bytes_q[s / 8];
         drive_bits(2'b00, {3'd0, cur[7 - (s % 8)]});
         if (s == 31) check("t1_valid_before_last", {31'd0, rd_if.rdata_valid_out}, 32'd0);
         pulse();
      end
      check("t1_valid", {31'd0, rd_if.rdata_valid_out}, 32'd1);
      check("t1_rdata", rd_if.rdata_out, 32'hEFBEADDE);
      check("t1_done", {31'd0, done}, 32'd1);
      step();
      check("t1_done_pulse", {31'd0, done}, 32'd0);
      check("t1_busy_fall", {31'd0, busy}, 32'd0);
      check("t1_accepted", {31'd0, rd_if.rdata_valid_out}, 32'd0);

      // Quad mode, 6 dummy samples, 3 bytes.
      bytes_q = '{8'h12, 8'h34, 8'h56};
      base = obs_q.size();
      d0 = done_cnt;
      start_xfer(2'b10, 5'd6, 8'd3);
      send_junk(6, 1'b1);
      send_bytes(2'b10, 1'b1);
      wait_idle("t2_idle");
      step();
      check("t2_nwords", 32'(obs_q.size() - base), 32'd1);
      if (obs_q.size() > base) check("t2_word", obs_q[base], 32'h00563412);
      check("t2_done_cnt", 32'(done_cnt - d0), 32'd1);

      // Dual mode, 8 bytes with ready low: second word overruns.
      rd_if.rdata_ready_in = 1'b0;
      bytes_q = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
      start_xfer(2'b01, 5'd0, 8'd8);
      for (int i = 0; i < 4; i++) send_byte(2'b01, bytes_q[i], 1'b0);
      check("t3_valid_w0", {31'd0, rd_if.rdata_valid_out}, 32'd1);
      check("t3_rdata_w0", rd_if.rdata_out, 32'h44332211);
      check("t3_no_overrun_yet", {31'd0, overrun}, 32'd0);
      for (int i = 4; i < 8; i++) send_byte(2'b01, bytes_q[i], 1'b1);
      check("t3_held_valid", {31'd0, rd_if.rdata_valid_out}, 32'd1);
      check("t3_held_rdata", rd_if.rdata_out, 32'h44332211);
      check("t3_overrun", {31'd0, overrun}, 32'd1);
      wait_idle("t3_idle");
      check("t3_overrun_sticky", {31'd0, overrun}, 32'd1);
      rd_if.rdata_ready_in = 1'b1;
      step();
      check("t3_drained", {31'd0, rd_if.rdata_valid_out}, 32'd0);
      start_xfer(2'b11, 5'd0, 8'd1);
      check("t3_overrun_cleared", {31'd0, overrun}, 32'd0);
      send_byte(2'b11, 8'h3C, 1'b1);
      wait_idle("t3b_idle");

      // Quad mode abort after a held word and three further samples.
      rd_if.rdata_ready_in = 1'b0;
      start_xfer(2'b10, 5'd0, 8'd8);
      for (int i = 0; i < 4; i++) send_byte(2'b10, 8'($urandom), 1'b0);
      check("t4_valid_before_abort", {31'd0, rd_if.rdata_valid_out}, 32'd1);
      send_junk(3, 1'b0);
      d0 = done_cnt;
      abort_in = 1'b1;
      step();
      abort_in = 1'b0;
      check("t4_busy", {31'd0, busy}, 32'd0);
      check("t4_valid", {31'd0, rd_if.rdata_valid_out}, 32'd0);
      check("t4_done", {31'd0, done}, 32'd0);
      rd_if.rdata_ready_in = 1'b1;
      send_junk(4, 1'b0);
      check("t4_idle_ignores_samples", {30'd0, busy, rd_if.rdata_valid_out}, 32'd0);
      check("t4_no_done", 32'(done_cnt - d0), 32'd0);

      // Asynchronous reset mid-DATA while a word is held.
      rd_if.rdata_ready_in = 1'b0;
      start_xfer(2'b00, 5'd0, 8'd6);
      for (int i = 0; i < 5; i++) send_byte(2'b00, 8'($urandom), 1'b0);
      check("t5_valid_pre", {31'd0, rd_if.rdata_valid_out}, 32'd1);
      #2 h_rstn = 1'b0;
      #1;
      check("t5_rdata", rd_if.rdata_out, 32'd0);
      check("t5_flags", {28'd0, rd_if.rdata_valid_out, busy, done, overrun}, 32'd0);
      #3 h_rstn = 1'b1;
      rd_if.rdata_ready_in = 1'b1;
      step();
      base = obs_q.size();
      start_xfer(2'b00, 5'd0, 8'd1);
      send_byte(2'b00, 8'hA5, 1'b1);
      wait_idle("t5_idle");
      step();
      check("t5_nwords", 32'(obs_q.size() - base), 32'd1);
      if (obs_q.size() > base) check("t5_word", obs_q[base], 32'h000000A5);

      // Zero-byte transfer with four dummy samples.
      b0 = busy_cnt;
      d0 = done_cnt;
      start_xfer(2'b01, 5'd4, 8'd0);
      send_junk(3, 1'b0);
      check("t6_no_early_done", {31'd0, done}, 32'd0);
      send_junk(1, 1'b0);
      check("t6_done", {31'd0, done}, 32'd1);
      check("t6_no_valid", {31'd0, rd_if.rdata_valid_out}, 32'd0);
      check("t6_busy_in_done", {31'd0, busy}, 32'd1);
      step();
      check("t6_busy_fall", {31'd0, busy}, 32'd0);
      step();
      check("t6_busy_cycles", {31'd0, (busy_cnt - b0) >= 5}, 32'd1);
      check("t6_done_cnt", 32'(done_cnt - d0), 32'd1);

      // Randomized transfers against the packing model.
      for (int t = 0; t < 20; t++) begin
         logic [1:0] mode;
         int dummy;
         int n;
         mode  = 2'($urandom_range(0, 3));
         dummy = $urandom_range(0, 7);
         n     = $urandom_range(1, 10);
         bytes_q.delete();
         for (int i = 0; i < n; i++) bytes_q.push_back(8'($urandom));
         build_exp();
         base = obs_q.size();
         d0 = done_cnt;
         start_xfer(mode, 5'(dummy), 8'(n));
         send_junk(dummy, 1'b1);
         send_bytes(mode, 1'b1);
         wait_idle($sformatf("rnd%0d_idle", t));
         step();
         check($sformatf("rnd%0d_nwords", t), 32'(obs_q.size() - base), 32'(exp_q.size()));
         for (int i = 0; i < exp_q.size(); i++) begin
            if (base + i < obs_q.size())
               check($sformatf("rnd%0d_word%0d", t, i), obs_q[base + i], exp_q[i]);
         end
         check($sformatf("rnd%0d_done", t), 32'(done_cnt - d0), 32'd1);
         check($sformatf("rnd%0d_overrun", t), {31'd0, overrun}, 32'd0);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/qspi_rx_datapath.md
# qspi_rx_datapath

Receive-side datapath of the QSPI controller. It samples flash read data on the io lines in single, dual or quad mode after a programmable number of dummy cycles. It assembles the data into little-endian 32-bit words and hands them to the AHB slave datapath over a valid/ready handshake. The block runs on h_clk and is clocked by sample-enable pulses that the controller derives from the generated sclk. The controller FSM sequences it after the command and address phases.

## Interface
- DATA_W, 32, width of the assembled word; fixed at 32, four bytes.
- LEN_W, 8, width of the transfer byte count.
- h_clk  input  1  system clock.
- h_rstn  input  1  reset; asynchronous, active-low.
- start_in  input  1  one-cycle pulse that starts a receive; ignored unless IDLE.
- abort_in  input  1  returns to IDLE and clears assembly, holding register and valid.
- no_io_lines_use_in  input  2  00 single (io1), 01 dual, 10 quad, 11 treated as single; latched at start.
- dummy_cycles_in  input  5  number of sample pulses discarded before data; latched at start.
- xfer_bytes_in  input  LEN_W  number of data bytes to receive; latched at start.
- sample_en_in  input  1  one h_clk pulse per sclk sampling edge.
- io0_in, io1_in, io2_in, io3_in  input  1 each  flash data lines.
- rdata_out  output  DATA_W  assembled word.
- rdata_valid_out  output  1  rdata_out holds an unconsumed word.
- rdata_ready_in  input  1  the consumer accepts the word when valid && ready.
- busy_out  output  1  high in any state except IDLE.
- rx_done_out  output  1  one-cycle pulse when the transfer completes.
- overrun_err_out  output  1  sticky; set when a word is dropped; cleared by start.

## Operation
- FSM states: IDLE, DUMMY, DATA, DONE.
  - IDLE→DUMMY on start_in if dummy_cycles_in≠0.
  - IDLE→DATA on start_in if dummy_cycles_in=0.
  - IDLE→DONE on start_in if dummy_cycles_in=0 and xfer_bytes_in=0.
  - DUMMY→DATA on the last dummy sample, or →DONE if the byte count is 0.
  - DATA→DONE when the final byte completes.
  - DONE→IDLE unconditionally.
- Sample width per sample_en_in pulse:
  - single: io1, 8 samples per byte.
  - dual: {io1,io0}, 4 samples per byte.
  - quad: {io3,io2,io1,io0}, 2 samples per byte.
- The first sample is the most significant bit(s) of the byte.
- Byte k of a word goes to rdata[8k+7:8k]; the first byte received lands in [7:0].
- A word is pushed to the holding register when its 4th byte completes, or when the final byte of the transfer completes.
  - For a partial final word, the unfilled upper bytes are zero.
- Counters:
  - sample-in-byte counter, 3 bits.
  - byte-in-word counter, 2 bits, wraps 3→0.
  - bytes-remaining counter, LEN_W bits, loaded at start, decrements per byte.
  - dummy counter, 5 bits.
- Overrun: if a push occurs while valid=1 and ready=0, the new word is discarded, overrun_err_out is set, and the held word is kept.
  - A push in the same cycle as an accept is legal: the new word replaces the old and valid stays 1.
- Priority order: h_rstn > abort_in > start_in > sample_en_in.
  - sample_en_in is ignored in IDLE and DONE.
- The holding register survives DONE, so the last word remains valid until it is accepted.

## Timing
- Reset values: rdata_out=0, rdata_valid_out=0, busy_out=0, rx_done_out=0, overrun_err_out=0, state IDLE, all counters 0.
- start_in at cycle t: busy_out=1 from t+1. The first sample_en_in counted is at t+1 or later.
- A sample is registered on the h_clk edge at which sample_en_in=1.
- Push latency: rdata_valid_out rises one cycle after the sample_en_in that completes the word.
- rx_done_out is asserted in the cycle the FSM is in DONE, which is the cycle after the final push (or after the final dummy sample when the byte count is 0). busy_out falls the cycle after that.
- abort_in at cycle t: state IDLE at t+1, rdata_valid_out=0 at t+1, no rx_done_out.
- Asynchronous reset mid-transfer clears every output immediately.

## Structure
- The shared package qspi_pkg holds:
  - rx_state_t enum.
  - io mode constants IO_MODE_SINGLE=2'b00, IO_MODE_DUAL=2'b01, IO_MODE_QUAD=2'b10.
  - samples-per-byte constants.
- The package is shared with the transmit datapath.
- Sub-module qspi_rx_shift_reg: a mode-aware 8-bit deserializer that outputs byte_out and byte_done. The FSM, word assembly, counters and handshake stay in the top module.

## Test plan
- Single mode, dummy 0, 4 bytes: drive 0xDE,0xAD,0xBE,0xEF on io1, MSB first, 32 pulses, ready=1. Expect rdata_out=32'hEFBEADDE, valid one cycle after pulse 32, then rx_done_out.
- Quad mode, dummy 6, 3 bytes: drive nibbles 1,2,3,4,5,6 after 6 junk samples. Expect rdata_out=32'h00563412 and a single word.
- Dual mode, 8 bytes, ready held low. Expect the first word to stay held, the second word dropped, and overrun_err_out=1. A new start_in clears the flag.
- Quad mode, 4 bytes, abort_in after 3 samples. Expect IDLE next cycle, valid=0, no rx_done_out, and sample_en_in ignored afterwards.
- Reset asserted mid-DATA with valid=1. Expect all outputs 0 asynchronously; after release, a fresh 1-byte transfer of 0xA5 gives 32'h000000A5.
- xfer_bytes_in=0, dummy 4. Expect rx_done_out after the 4th sample, no valid, busy_out high for 5 cycles min.
